// File: rtl/piso_tx_pkg.sv
// Shared state encoding and counter sizing for the PISO transmit controller.
package piso_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Counter width for a count of n values; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit parallel-load register shifting one bit per strobe with zero fill.
module piso_shift_core
   import piso_tx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             msb_first,
   input  logic [WIDTH-1:0] data,
   output logic             sd
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= data;
      end else if (shift) begin
         sr <= msb_first ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      end
   end

   assign sd = msb_first ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/piso_tx_controller.sv
// Accepts parallel words over valid/ready, serialises them through the shift core
// with DIV cycles per bit, pulses done per word and enforces a GAP-cycle idle.
module piso_tx_controller
   import piso_tx_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DIV       = 1,
   parameter int GAP       = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_sd,
   output logic             o_sd_valid,
   output logic             o_busy,
   output logic             o_done
);

   localparam int BW = cnt_width(WIDTH);
   localparam int DW = cnt_width(DIV);
   localparam int GW = cnt_width(GAP + 1);

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   state_t        state;
   logic [BW-1:0] bit_cnt;
   logic [DW-1:0] div_cnt;
   logic [GW-1:0] gap_cnt;
   logic          done_q;
   logic          accept;
   logic          shift;
   logic          core_sd;

   // Reset has priority over accept because o_ready already masks i_rst.
   assign o_ready    = (state == ST_IDLE) && !i_rst;
   assign accept     = i_valid && o_ready;
   assign shift      = (state == ST_SHIFT) && (div_cnt == DIV_LAST);
   assign o_sd_valid = (state == ST_SHIFT);
   assign o_sd       = core_sd && (state == ST_SHIFT);
   assign o_busy     = (state != ST_IDLE);
   assign o_done     = done_q;

   piso_shift_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk       (i_clk),
      .rst       (i_rst),
      .load      (accept),
      .shift     (shift),
      .msb_first (MSB_FIRST),
      .data      (i_data),
      .sd        (core_sd)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         div_cnt <= '0;
         gap_cnt <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_valid) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
                  div_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     gap_cnt <= '0;
                     done_q  <= 1'b1;
                     state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_tx_controller.sv
// Directed bench: u0 uses defaults with GAP=0, u1 is LSB-first with DIV=3 and GAP=2.
module tb_piso_tx_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] data0, data1;
   logic       valid0, valid1;
   logic       ready0, sd0, sdv0, busy0, done0;
   logic       ready1, sd1, sdv1, busy1, done1;
   int         tests = 0;
   int         fails = 0;
   logic [4:0] obs, exp;
   logic [3:0] w;

   always #5 clk = ~clk;

   piso_tx_controller #(.WIDTH(4), .DIV(1), .GAP(0), .MSB_FIRST(1'b1)) u0 (
      .i_clk(clk), .i_rst(rst), .i_data(data0), .i_valid(valid0), .o_ready(ready0),
      .o_sd(sd0), .o_sd_valid(sdv0), .o_busy(busy0), .o_done(done0)
   );

   piso_tx_controller #(.WIDTH(4), .DIV(3), .GAP(2), .MSB_FIRST(1'b0)) u1 (
      .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1), .o_ready(ready1),
      .o_sd(sd1), .o_sd_valid(sdv1), .o_busy(busy1), .o_done(done1)
   );

   // Advance into the cycle following the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observation vectors are {o_sd, o_sd_valid, o_busy, o_done, o_ready}.
   task automatic test_reset();
      rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
      step(); step();
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00000) begin fails++; $display("[TB] FAIL reset_u0: got %b, expected %b", obs, 5'b00000); end
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00000) begin fails++; $display("[TB] FAIL reset_u1: got %b, expected %b", obs, 5'b00000); end
      rst = 1'b0;
      step();
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00001) begin fails++; $display("[TB] FAIL post_reset_u0: got %b, expected %b", obs, 5'b00001); end
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00001) begin fails++; $display("[TB] FAIL post_reset_u1: got %b, expected %b", obs, 5'b00001); end
   endtask

   task automatic test_msb_default();
      w = 4'b1010; data0 = w; valid0 = 1'b1;
      step();
      valid0 = 1'b0;
      for (int j = 0; j < 4; j++) begin
         exp = {w[3-j], 4'b1100};
         obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
         if (obs !== exp) begin fails++; $display("[TB] FAIL msb_bit%0d: got %b, expected %b", j, obs, exp); end
         step();
      end
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00011) begin fails++; $display("[TB] FAIL msb_done: got %b, expected %b", obs, 5'b00011); end
      step();
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00001) begin fails++; $display("[TB] FAIL msb_idle: got %b, expected %b", obs, 5'b00001); end
   endtask

   task automatic test_lsb_div3();
      w = 4'b1010; data1 = w; valid1 = 1'b1;
      step();
      valid1 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         exp = {w[c/3], 4'b1100};
         obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
         if (obs !== exp) begin fails++; $display("[TB] FAIL lsb_cycle%0d: got %b, expected %b", c, obs, exp); end
         step();
      end
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00110) begin fails++; $display("[TB] FAIL lsb_done_gap1: got %b, expected %b", obs, 5'b00110); end
      step();
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00100) begin fails++; $display("[TB] FAIL lsb_gap2: got %b, expected %b", obs, 5'b00100); end
      step();
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00001) begin fails++; $display("[TB] FAIL lsb_ready: got %b, expected %b", obs, 5'b00001); end
   endtask

   // Producer keeps valid high and scrambles data while the controller is busy.
   task automatic test_ignore_busy();
      w = 4'b0110; data1 = w; valid1 = 1'b1;
      step();
      for (int c = 0; c < 12; c++) begin
         exp = {w[c/3], 4'b1100};
         obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
         if (obs !== exp) begin fails++; $display("[TB] FAIL ign_cycle%0d: got %b, expected %b", c, obs, exp); end
         data1 = data1 ^ 4'b1011;
         step();
      end
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00110) begin fails++; $display("[TB] FAIL ign_gap1: got %b, expected %b", obs, 5'b00110); end
      data1 = data1 ^ 4'b0101;
      step();
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00100) begin fails++; $display("[TB] FAIL ign_gap2: got %b, expected %b", obs, 5'b00100); end
      data1 = data1 ^ 4'b1110;
      step();
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00001) begin fails++; $display("[TB] FAIL ign_ready: got %b, expected %b", obs, 5'b00001); end
      w = 4'b1001; data1 = w;
      step();
      valid1 = 1'b0; data1 = 4'b0000;
      for (int c = 0; c < 12; c++) begin
         exp = {w[c/3], 4'b1100};
         obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
         if (obs !== exp) begin fails++; $display("[TB] FAIL ign_word2_cycle%0d: got %b, expected %b", c, obs, exp); end
         step();
      end
      obs = {sd1, sdv1, busy1, done1, ready1}; tests++;
      if (obs !== 5'b00110) begin fails++; $display("[TB] FAIL ign_word2_done: got %b, expected %b", obs, 5'b00110); end
      step(); step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] stream;
      stream = 8'b1100_0011;
      data0 = 4'b1100; valid0 = 1'b1;
      step();
      data0 = 4'b0011;
      for (int j = 0; j < 4; j++) begin
         exp = {stream[7-j], 4'b1100};
         obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
         if (obs !== exp) begin fails++; $display("[TB] FAIL b2b_w1_bit%0d: got %b, expected %b", j, obs, exp); end
         step();
      end
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00011) begin fails++; $display("[TB] FAIL b2b_gap_cycle: got %b, expected %b", obs, 5'b00011); end
      step();
      valid0 = 1'b0;
      for (int j = 0; j < 4; j++) begin
         exp = {stream[3-j], 4'b1100};
         obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
         if (obs !== exp) begin fails++; $display("[TB] FAIL b2b_w2_bit%0d: got %b, expected %b", j, obs, exp); end
         step();
      end
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00011) begin fails++; $display("[TB] FAIL b2b_done2: got %b, expected %b", obs, 5'b00011); end
      step();
   endtask

   task automatic test_reset_abort();
      data0 = 4'b1111; valid0 = 1'b1;
      step();
      valid0 = 1'b0;
      for (int j = 0; j < 2; j++) begin
         obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
         if (obs !== 5'b11100) begin fails++; $display("[TB] FAIL abort_bit%0d: got %b, expected %b", j, obs, 5'b11100); end
         if (j == 0) step();
      end
      rst = 1'b1;
      step();
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00000) begin fails++; $display("[TB] FAIL abort_in_reset: got %b, expected %b", obs, 5'b00000); end
      rst = 1'b0;
      step();
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00001) begin fails++; $display("[TB] FAIL abort_ready: got %b, expected %b", obs, 5'b00001); end
      step();
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00001) begin fails++; $display("[TB] FAIL abort_no_done: got %b, expected %b", obs, 5'b00001); end
      w = 4'b0110; data0 = w; valid0 = 1'b1;
      step();
      valid0 = 1'b0;
      for (int j = 0; j < 4; j++) begin
         exp = {w[3-j], 4'b1100};
         obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
         if (obs !== exp) begin fails++; $display("[TB] FAIL abort_new_bit%0d: got %b, expected %b", j, obs, exp); end
         step();
      end
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00011) begin fails++; $display("[TB] FAIL abort_new_done: got %b, expected %b", obs, 5'b00011); end
      step();
   endtask

   task automatic test_reset_vs_accept();
      rst = 1'b1; data0 = 4'b1111; valid0 = 1'b1;
      step();
      valid0 = 1'b0;
      obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
      if (obs !== 5'b00000) begin fails++; $display("[TB] FAIL rva_reset: got %b, expected %b", obs, 5'b00000); end
      rst = 1'b0;
      for (int j = 0; j < 2; j++) begin
         step();
         obs = {sd0, sdv0, busy0, done0, ready0}; tests++;
         if (obs !== 5'b00001) begin fails++; $display("[TB] FAIL rva_no_accept%0d: got %b, expected %b", j, obs, 5'b00001); end
      end
   endtask

   initial begin
      test_reset();
      test_msb_default();
      test_lsb_div3();
      test_ignore_busy();
      test_back_to_back();
      test_reset_abort();
      test_reset_vs_accept();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/piso_tx_controller.md
# piso_tx_controller

Sequencing controller for the team's 4-bit parallel-in/serial-out shift path. Accepts parallel words from an upstream producer over a valid/ready handshake, loads them into an internal PISO register, and shifts them out one bit per bit period with a qualifying strobe. A completion pulse is issued per word, and a programmable inter-word gap is enforced. It sits between a word source (register file, FIFO) and a serial line driver.

## Interface
- WIDTH, 4, word width in bits (≥2)
- DIV, 1, clock cycles per serial bit (≥1)
- GAP, 1, idle cycles inserted after each word before accepting the next (≥0)
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first, 0 = bit 0 first

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  WIDTH  parallel word, sampled on accept
- i_valid  in  1  producer has a word
- o_ready  out  1  controller can accept a word this cycle
- o_sd  out  1  serial data bit
- o_sd_valid  out  1  o_sd carries a frame bit
- o_busy  out  1  frame or gap in progress
- o_done  out  1  one-cycle pulse after the last bit of a word

## Operation
- States: IDLE, SHIFT, GAP. All outputs are derived from registered state; o_ready = (state==IDLE) && !i_rst.
- IDLE: o_ready=1. Accept = i_valid && o_ready at a rising edge. On accept: load i_data into the shift register, clear the bit counter and divider, and go to SHIFT. i_valid without o_ready is ignored; the producer holds i_data and i_valid until accept.
- SHIFT: o_sd = current output bit (MSB or LSB of the shift register per MSB_FIRST), o_sd_valid=1, o_busy=1.
  - The divider counts 0..DIV-1.
  - At DIV-1, the register shifts by one (zero fill) and the bit counter increments.
  - At bit counter WIDTH-1 with divider DIV-1, the state goes to GAP if GAP>0, else to IDLE.
- GAP: o_busy=1, o_sd=0, o_sd_valid=0. The gap counter counts GAP cycles, then the state goes to IDLE.
- o_done=1 for exactly one cycle: the first cycle after the last bit period (first GAP cycle, or the IDLE cycle when GAP=0).
- o_sd=0 whenever o_sd_valid=0.
- Counter widths: $clog2(WIDTH), $clog2(DIV) (min 1), $clog2(GAP+1) (min 1). Counters never wrap mid-frame.
- Reset values (any state, including mid-frame or mid-gap):
  - state=IDLE; shift register, counters, o_sd, o_sd_valid, o_busy, o_done = 0.
  - o_ready=0 while i_rst=1, and 1 in the first cycle after i_rst falls.
  - Aborted words produce no o_done.
- Simultaneous i_rst and accept: reset wins and the word is not taken.

## Timing
- Accept at edge k. o_sd_valid is high in cycles k+1 .. k+WIDTH·DIV.
- Bit j (0-based, in shift order) is presented in cycles k+1+j·DIV .. k+(j+1)·DIV.
- o_done is high in cycle k+WIDTH·DIV+1.
- o_ready returns in cycle k+WIDTH·DIV+1+GAP. Minimum word period is WIDTH·DIV+1+GAP cycles.
- Latency from accept to first bit is 1 cycle. There is no combinational path from i_valid or i_data to any output.

## Structure
- Package piso_tx_pkg: state enum/localparams (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2) and a counter-width helper function.
- One sub-module, piso_shift_core, provides the WIDTH-bit load/shift register.
  - Inputs: load, shift, parallel data, direction.
  - Output: serial bit.
  - Synchronous reset to 0.
  - The FSM, divider, bit counter and gap counter stay in the top level.

## Test plan
- Defaults, reset 2 cycles then i_data=4'b1010, i_valid=1 → o_sd 1,0,1,0 in cycles k+1..k+4 with o_sd_valid=1; o_done at k+5; o_ready at k+6.
- MSB_FIRST=0, i_data=4'b1010 → o_sd 0,1,0,1; DIV=3 run → each bit held exactly 3 cycles, o_done at k+13.
- Back-to-back, i_valid held high with 4'b1100 then 4'b0011, GAP=0 → second accept at k+5; serial stream 1,1,0,0,(idle 1 cycle, o_sd_valid=0),0,0,1,1.
- i_rst pulsed for 1 cycle after the second bit of 4'b1111 → o_sd_valid and o_busy low the next cycle, no o_done, o_ready=1 the cycle after i_rst falls. A new word 4'b0110 then transmits correctly.
- i_valid asserted during SHIFT/GAP with changing i_data → ignored, o_ready=0 throughout. The word sampled is the one present at the IDLE accept edge.
- i_rst and i_valid high in the same cycle → no accept, no o_sd_valid in the following cycles.
